// File: rtl/rsa_4k_pkg.sv
// Shared types and helpers for the rsa_4k modular-exponentiation engine.
// bit_length() accepts operands up to MAX_WIDTH bits; narrower operands are zero-extended by the caller.
package rsa_4k_pkg;

  localparam int WIDTH_DEF = 4096;
  localparam int MAX_WIDTH = 4096;
  localparam int LEN_W     = $clog2(MAX_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCAN,
    SQR,
    MUL,
    FIN
  } state_t;

  // Priority encoder: index of the most significant set bit plus one, or zero for v == 0.
  function automatic logic [LEN_W-1:0] bit_length(input logic [MAX_WIDTH-1:0] v);
    logic [LEN_W-1:0] len;
    len = '0;
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if (v[k]) len = LEN_W'(k + 1);
    end
    return len;
  endfunction

endpackage

// File: rtl/rsa_4k_modmul.sv
// Bit-serial interleaved (Blakley) modular multiplier: p = a*b mod n, one bit of b per cycle.
// a, b and n must stay stable while busy; ready pulses for one cycle when p is valid.
module rsa_4k_modmul
  import rsa_4k_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           n,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  output logic [WIDTH-1:0]           p,
  output logic                       ready
);

  localparam int IW = $clog2(WIDTH);
  localparam int EW = WIDTH + 2;

  logic          busy;
  logic [IW-1:0] j;
  logic [EW-1:0] n_ext;
  logic [EW-1:0] t0;
  logic [EW-1:0] t1;
  logic [WIDTH-1:0] p_next;

  // 2p + a < 3n, so two conditional subtractions always bring the sum back below n.
  always_comb begin
    n_ext  = EW'(n);
    t0     = {1'b0, p, 1'b0} + (b[j] ? EW'(a) : EW'(0));
    t1     = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    p_next = (t1 >= n_ext) ? WIDTH'(t1 - n_ext) : t1[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= 1'b0;
      j     <= '0;
      p     <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        j    <= IW'(len - 1'b1);
        p    <= '0;
      end else if (busy) begin
        p <= p_next;
        if (j == '0) begin
          busy  <= 1'b0;
          ready <= 1'b1;
        end else begin
          j <= j - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_4k.sv
// Left-to-right square-and-multiply modular exponentiation: cypher = message^exponent mod modulus.
// Define RSA_LZ_SKIP_EN to skip leading zero exponent bits instead of squaring acc=1.
module rsa_4k
  import rsa_4k_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cypher,
  output logic             done
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] msg_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] acc;
  logic [LW-1:0]    len_r;
  logic [IW-1:0]    idx;
  logic             mm_start;
  logic             mm_bsel;
  logic             mm_ready;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_p;
`ifdef RSA_LZ_SKIP_EN
  logic             seen_one;
`endif

  assign mm_b = mm_bsel ? msg_r : acc;

  rsa_4k_modmul #(
    .WIDTH(WIDTH)
  ) u_modmul (
    .clk  (clk),
    .reset(reset),
    .start(mm_start),
    .a    (acc),
    .b    (mm_b),
    .n    (mod_r),
    .len  (len_r),
    .p    (mm_p),
    .ready(mm_ready)
  );

  // FIN is left only once go is seen low, so a held go cannot retrigger a run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      cypher   <= '0;
      msg_r    <= '0;
      exp_r    <= '0;
      mod_r    <= '0;
      acc      <= '0;
      len_r    <= '0;
      idx      <= '0;
      mm_start <= 1'b0;
      mm_bsel  <= 1'b0;
`ifdef RSA_LZ_SKIP_EN
      seen_one <= 1'b0;
`endif
    end else begin
      mm_start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            msg_r <= message;
            exp_r <= exponent;
            mod_r <= modulus;
            state <= SETUP;
          end
        end

        SETUP: begin
          len_r <= LW'(bit_length(MAX_WIDTH'(mod_r)));
          idx   <= IW'(WIDTH - 1);
`ifdef RSA_LZ_SKIP_EN
          seen_one <= 1'b0;
`endif
          if (mod_r < WIDTH'(2)) begin
            acc   <= '0;
            state <= FIN;
          end else begin
            acc   <= WIDTH'(1);
            state <= SCAN;
          end
        end

        SCAN: begin
`ifdef RSA_LZ_SKIP_EN
          if (!seen_one) begin
            if (exp_r[idx]) begin
              acc      <= msg_r;
              seen_one <= 1'b1;
            end
            if (idx == '0) state <= FIN;
            else idx <= idx - 1'b1;
          end else begin
            mm_start <= 1'b1;
            mm_bsel  <= 1'b0;
            state    <= SQR;
          end
`else
          mm_start <= 1'b1;
          mm_bsel  <= 1'b0;
          state    <= SQR;
`endif
        end

        SQR: begin
          if (mm_ready) begin
            acc <= mm_p;
            if (exp_r[idx]) begin
              mm_start <= 1'b1;
              mm_bsel  <= 1'b1;
              state    <= MUL;
            end else if (idx == '0) begin
              state <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SCAN;
            end
          end
        end

        MUL: begin
          if (mm_ready) begin
            acc <= mm_p;
            if (idx == '0) begin
              state <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SCAN;
            end
          end
        end

        FIN: begin
          if (!done) begin
            cypher <= acc;
            done   <= 1'b1;
          end else if (!go) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_4k.sv
// Directed and random checks of rsa_4k at a reduced width, with a queue of expected results.
module tb_rsa_4k;

  localparam int W       = 64;
  localparam int TIMEOUT = 30000;

  logic         clk;
  logic         reset;
  logic         go;
  logic [W-1:0] message;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic [W-1:0] cypher;
  logic         done;

  int           total;
  int           bad;
  logic [W-1:0] sbq[$];

  rsa_4k #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .message (message),
    .exponent(exponent),
    .modulus (modulus),
    .cypher  (cypher),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference exponentiation using plain wide multiply and remainder.
  function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] r;
    logic [2*W-1:0] nn;
    logic [2*W-1:0] mm;
    if (n < W'(2)) return '0;
    r  = 1;
    nn = {{W{1'b0}}, n};
    mm = {{W{1'b0}}, m};
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * mm) % nn;
    end
    return r[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic driveInputs(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
    message  = m;
    exponent = e;
    modulus  = n;
    go       = 1'b1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] e,
                               input logic [W-1:0] n, input logic [W-1:0] want);
    sbq.push_back(want);
    driveInputs(m, e, n);
  endtask

  task automatic checkOutput(input string tag);
    bit           seen;
    logic [W-1:0] want;
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT && !seen; c++) begin
      tick();
      seen = (done === 1'b1);
    end
    total++;
    assert (seen)
    else begin
      bad++;
      $error("[TB] FAIL %s_done: observed=0 expected=1 within %0d cycles", tag, TIMEOUT);
    end
    want = sbq.pop_front();
    checkEq({tag, "_cypher"}, cypher, want);
  endtask

  task automatic releaseGo(input string tag);
    go = 1'b0;
    tick();
    checkBit({tag, "_release"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rm;
    logic [W-1:0] re;
    logic [W-1:0] rn;

    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    go       = 1'b0;
    message  = '0;
    exponent = '0;
    modulus  = '0;

    tick();
    tick();
    reset = 1'b1;
    tick();
    checkBit("reset_done", done, 1'b0);
    checkEq("reset_cypher", cypher, '0);

    $display("[TB] encrypt 8^13 mod 77");
    applyStimulus(W'(8), W'(13), W'(77), W'(50));
    checkOutput("enc");
    repeat (5) tick();
    checkBit("hold_done", done, 1'b1);
    checkEq("hold_cypher", cypher, W'(50));
    releaseGo("enc");
    checkEq("keep_cypher", cypher, W'(50));

    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkEq("pulse_cypher", cypher, '0);
    $display("[TB] decrypt 50^37 mod 77");
    applyStimulus(W'(50), W'(37), W'(77), W'(8));
    checkOutput("dec");
    releaseGo("dec");

    applyStimulus(W'(5), W'(0), W'(77), W'(1));
    checkOutput("exp0");
    releaseGo("exp0");

    applyStimulus(W'(0), W'(3), W'(1), W'(0));
    checkOutput("mod1");
    releaseGo("mod1");

    applyStimulus(W'(3), W'(5), W'(100), W'(43));
    checkOutput("even");
    releaseGo("even");

    $display("[TB] random full-width operands");
    for (int k = 0; k < 2; k++) begin
      rn = {$urandom(), $urandom()};
      rn[W-1] = 1'b1;
      if (k == 1) rn[0] = 1'b0;
      rm = {$urandom(), $urandom()};
      rm = rm % rn;
      re = {$urandom(), $urandom()};
      applyStimulus(rm, re, rn, modexp(rm, re, rn));
      checkOutput($sformatf("rand%0d", k));
      releaseGo($sformatf("rand%0d", k));
    end

    $display("[TB] abort by reset");
    driveInputs(W'(8), W'(13), W'(77));
    repeat (30) tick();
    checkBit("abort_mid_done", done, 1'b0);
    reset = 1'b0;
    go    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkBit("abort_done", done, 1'b0);
    checkEq("abort_cypher", cypher, '0);
    repeat (20) tick();
    checkBit("abort_quiet", done, 1'b0);

    applyStimulus(W'(8), W'(13), W'(77), W'(50));
    repeat (3) tick();
    go = 1'b0;
    checkOutput("gofall");
    tick();
    checkBit("gofall_drop", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_4k.md
Name: rsa_4k

Overview:
- Iterative modular-exponentiation engine for RSA: cypher = message^exponent mod modulus, on operands up to WIDTH (4096) bits.
- Sits behind a simple go/done level handshake. The same block performs encryption and decryption; only the exponent differs.
- Left-to-right binary square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier.

Parameters:
- WIDTH, 4096, operand/result width in bits (minimum 8).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- go  in  1  start request, level-sensitive
- message  in  WIDTH  base; must be < modulus
- exponent  in  WIDTH  exponent
- modulus  in  WIDTH  modulus; any value ≥ 2, need not be odd
- cypher  out  WIDTH  result, valid while done=1
- done  out  1  completion flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset=0 at a clk edge):
  - state←IDLE, done←0, cypher←0, all internal registers cleared.
  - Reset mid-operation aborts the computation immediately; no done is produced.
- FSM states: IDLE, SETUP, SCAN, SQR, MUL, FIN.
- IDLE: when go=1, latch message, exponent and modulus into internal registers → SETUP. Inputs may change after this without effect.
- SETUP (1 cycle):
  - L = bit length of modulus (index of its MSB + 1), via a priority encoder.
  - acc←1, bit index i←WIDTH-1.
  - If modulus<2: acc←0 and go straight to FIN.
- SCAN: walks the exponent from the MSB down.
  - For each bit: start SQR (acc←acc·acc mod n), then, if exponent[i]=1, MUL (acc←acc·message mod n).
  - Decrement i after each bit; when the bit at i=0 has been processed → FIN.
  - exponent=0 gives acc=1.
- Multiplier (sub-module): computes P=a·b mod n, with a,b<n.
  - Iterates j=L-1..0, one bit per cycle: P←2P+b[j]·a, then subtract n at most twice so that P<n.
  - Latency: L cycles plus 1 start/handshake cycle.
  - Bits of b at or above L are zero by precondition and are skipped.
- FIN: cypher←acc, done←1.
  - cypher and done hold until go is sampled 0, then done←0 and return to IDLE. cypher keeps its last value.
  - go held high after done does not restart; a new run requires go to fall and then rise again.
- go falling during a computation is ignored; the run completes and done asserts. It then deasserts on the next cycle because go=0.
- message ≥ modulus is a precondition violation; the result is unspecified, but the FSM must still terminate.
- Arithmetic uses WIDTH+2-bit intermediates so 2P+a cannot overflow.

Optional Feature:
- RSA_LZ_SKIP_EN
  - Defined: SCAN skips leading zero exponent bits at 1 cycle per bit, without issuing squarings, until the first 1. The first 1 sets acc←message directly instead of square+multiply.
  - Undefined: every bit from WIDTH-1 down is processed. Squaring acc=1 is still performed, costing L+1 cycles each.
  - The numerical result is identical either way; only latency differs.

Decomposition:
- Package rsa_4k_pkg holds:
  - WIDTH default
  - state enum (IDLE, SETUP, SCAN, SQR, MUL, FIN)
  - the bit-length (MSB-index) function
- One sub-module: rsa_4k_modmul, the bit-serial interleaved modular multiplier.
  - Ports: clk, reset, start, a, b, n, len, p, ready.

Test Plan:
- reset=0 for 2 cycles, then reset=1 → done=0, cypher=0.
- message=8, exponent=13, modulus=77, go=1 → done within bounded cycles, cypher=50. Drop go → done=0 the next cycle.
- Then reset pulse, message=50, exponent=37, modulus=77, go=1 → cypher=8 (decrypt round trip).
- exponent=0, modulus=77, message=5 → cypher=1. modulus=1 → cypher=0.
- Even modulus: message=3, exponent=5, modulus=100 → cypher=43. Also a WIDTH-bit random triple checked against a reference model.
- Assert reset=0 mid-computation → done stays 0. A subsequent go with 8/13/77 → cypher=50. Run with and without RSA_LZ_SKIP_EN; results must match.
